instr_loader: RTL and testbench

//  Writer side of the instruction-memory interface. It receives a byte stream over a

---
 rtl/instr_loader.sv | 186 ++++++++++++++++++
 tb/tb_instr_loader.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Writer side of the instruction-memory interface. Accepts a byte stream over
//   a valid/ready handshake, assembles big-endian 32-bit words and writes them
//   to consecutive word addresses starting at 0. Every written word's opcode is
//   checked against the set the main decoder supports.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       1-cycle pulse, begins a new load (ignored unless idle)
//   byte_valid  byte_data valid
//   byte_data   stream byte, most significant byte of each word first
//   byte_last   qualifies byte_valid: final byte of the program
//   byte_ready  loader accepts a byte this cycle
//   imem_we     instruction-memory write strobe
//   imem_addr   word address for the write
//   imem_wdata  word to write
//   busy        high while loading or writing
//   done        1-cycle pulse when the load completes
//   word_count  words written in the current/last load
//   illegal_op  sticky: a written word had an unsupported opcode
//   overflow    sticky: memory filled before the stream finished
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              illegal_op,
  output logic              overflow
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       asm_q, asm_d;
  logic              last_q, last_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ill_q, ill_d;
  logic              ovf_q, ovf_d;
  logic              byte_ready_q, byte_ready_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       shifted;

  function automatic logic opcode_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b001000, 6'b000100,
      6'b000010, 6'b100011, 6'b101011: opcode_legal = 1'b1;
      default:                         opcode_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    asm_d   = asm_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    ovf_d   = ovf_q;
    shifted = {asm_q[23:0], byte_data};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = '0;
          cnt_d   = '0;
          ill_d   = 1'b0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          asm_d   = '0;
          last_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // byte_ready_q is exactly "state is LOAD", so it doubles as the accept term.
        if (byte_valid && byte_ready_q) begin
          idx_d = idx_q + 2'd1;
          asm_d = shifted;
          if (byte_last) begin
            // Short final word: push the received bytes to the top and zero-fill.
            // Stale bytes from the previous word shift out the top.
            case (idx_q)
              2'd0:    asm_d = {shifted[7:0],  24'h0};
              2'd1:    asm_d = {shifted[15:0], 16'h0};
              2'd2:    asm_d = {shifted[23:0], 8'h0};
              default: asm_d = shifted;
            endcase
            last_d  = 1'b1;
            state_d = S_WRITE;
          end else if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (!opcode_legal(asm_q[31:26])) ill_d = 1'b1;
        idx_d = '0;
        // The address saturates at the top of memory instead of wrapping.
        if (addr_q != ADDR_MAX) addr_d = addr_q + 1'b1;
        if (last_q) begin
          state_d = S_DONE;
        end else if (addr_q == ADDR_MAX) begin
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  assign byte_ready_d = (state_d == S_LOAD);
  assign we_d         = (state_d == S_WRITE);
  assign busy_d       = (state_d == S_LOAD) || (state_d == S_WRITE);
  assign done_d       = (state_d == S_DONE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      addr_q       <= '0;
      asm_q        <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      ill_q        <= 1'b0;
      ovf_q        <= 1'b0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      asm_q        <= asm_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      ill_q        <= ill_d;
      ovf_q        <= ovf_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = asm_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = cnt_q;
  assign illegal_op = ill_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//   Directed bench for instr_loader. Two instances share the stimulus: one with
//   the default 64-word memory and one with a 4-word memory for the overflow
//   case. A negedge monitor records every write into a shadow memory.
// -----------------------------------------------------------------------------
module tb_instr_loader;

  logic       clk = 1'b0;
  logic       reset, start, byte_valid, byte_last;
  logic [7:0] byte_data;

  always #5 clk = ~clk;

  logic        br6, we6, busy6, done6, ill6, ovf6;
  logic [5:0]  addr6;
  logic [31:0] wdata6;
  logic [6:0]  wc6;

  logic        br2, we2, busy2, done2, ill2, ovf2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  wc2;

  instr_loader #(.ADDR_W(6)) dut6 (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(br6),
    .imem_we(we6), .imem_addr(addr6), .imem_wdata(wdata6), .busy(busy6),
    .done(done6), .word_count(wc6), .illegal_op(ill6), .overflow(ovf6)
  );

  instr_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(br2),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2), .busy(busy2),
    .done(done2), .word_count(wc2), .illegal_op(ill2), .overflow(ovf2)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor
  logic [31:0] mem6 [64];
  logic [31:0] mem2 [4];
  int  wr6, wr2, done6_cnt, done2_cnt, first_we6, done_run6, max_done_run6, last_addr6;
  bit  prev_we6, dbl_we6;

  always @(negedge clk) begin
    if (we6) begin
      mem6[addr6] = wdata6;
      last_addr6  = int'(addr6);
      if (wr6 == 0) first_we6 = cyc;
      wr6++;
      if (prev_we6) dbl_we6 = 1'b1;
    end
    prev_we6 = we6;
    if (done6) begin
      done6_cnt++;
      done_run6++;
      if (done_run6 > max_done_run6) max_done_run6 = done_run6;
    end else begin
      done_run6 = 0;
    end
    if (we2) begin
      mem2[addr2] = wdata2;
      wr2++;
    end
    if (done2) done2_cnt++;
  end

  task automatic clear_mon();
    for (int i = 0; i < 64; i++) mem6[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++)  mem2[i] = 32'hDEAD_BEEF;
    wr6 = 0; wr2 = 0; done6_cnt = 0; done2_cnt = 0; first_we6 = -1;
    done_run6 = 0; max_done_run6 = 0; last_addr6 = -1; dbl_we6 = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; byte_data = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offers one byte for up to 30 cycles; ok=1 when it was accepted, acc_cyc is
  // the cycle counter value right after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input bit last, input int gap,
                           input bit use2, output bit ok, output int acc_cyc);
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1; byte_data = d; byte_last = last;
    ok = 1'b0; acc_cyc = -1;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if ((use2 ? br2 : br6) === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1; acc_cyc = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit last, input bit use2,
                           output int first_cyc, output int last_cyc);
    bit ok;
    int c;
    for (int b = 0; b < 4; b++) begin
      send_byte(w[31-8*b -: 8], last && (b == 3), 0, use2, ok, c);
      if (b == 0) first_cyc = c;
      last_cyc = c;
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL byte_accept: byte %0d of word %h not accepted (ready=0), required accepted", b, w);
      end
    end
  endtask

  task automatic wait_done(input bit use2);
    int n = 0;
    while ((use2 ? done2_cnt : done6_cnt) == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((use2 ? done2_cnt : done6_cnt) == 0) begin
      failures++;
      $display("FAIL done_timeout: done seen 0 times in 60 cycles, required 1");
    end
    tick();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({br6, we6, addr6, wdata6, busy6, done6, wc6, ill6, ovf6} !== 51'd0) begin
      failures++;
      $display("FAIL reset_outputs_a6: got %h required 0",
               {br6, we6, addr6, wdata6, busy6, done6, wc6, ill6, ovf6});
    end
    checks++;
    if ({br2, we2, addr2, wdata2, busy2, done2, wc2, ill2, ovf2} !== 43'd0) begin
      failures++;
      $display("FAIL reset_outputs_a2: got %h required 0",
               {br2, we2, addr2, wdata2, busy2, done2, wc2, ill2, ovf2});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_two_words();
    int f0, l0, f1, l1;
    apply_reset();
    clear_mon();
    pulse_start();
    send_word(32'h2008_0005, 1'b0, 1'b0, f0, l0);
    send_word(32'h0000_0000, 1'b1, 1'b0, f1, l1);
    wait_done(1'b0);
    checks++;
    if (mem6[0] !== 32'h2008_0005) begin
      failures++; $display("FAIL two_words_addr0: got %h required 20080005", mem6[0]);
    end
    checks++;
    if (mem6[1] !== 32'h0000_0000) begin
      failures++; $display("FAIL two_words_addr1: got %h required 00000000", mem6[1]);
    end
    checks++;
    if (wr6 !== 2) begin
      failures++; $display("FAIL two_words_writes: got %0d required 2", wr6);
    end
    checks++;
    if (wc6 !== 7'd2) begin
      failures++; $display("FAIL two_words_count: got %0d required 2", wc6);
    end
    checks++;
    if ({ill6, ovf6} !== 2'b00) begin
      failures++; $display("FAIL two_words_flags: got ill=%b ovf=%b required 0 0", ill6, ovf6);
    end
    checks++;
    if (max_done_run6 !== 1) begin
      failures++; $display("FAIL two_words_done_len: got %0d cycles required 1", max_done_run6);
    end
    // Write strobe in the cycle right after the 4th byte; next byte two cycles later.
    checks++;
    if (first_we6 !== l0) begin
      failures++; $display("FAIL write_latency: we at cycle %0d required %0d", first_we6, l0);
    end
    checks++;
    if (f1 !== l0 + 2) begin
      failures++; $display("FAIL ready_latency: next byte at cycle %0d required %0d", f1, l0 + 2);
    end
    checks++;
    if ({br6, busy6} !== 2'b00) begin
      failures++; $display("FAIL two_words_idle: got ready=%b busy=%b required 0 0", br6, busy6);
    end
  endtask

  task automatic test_illegal_then_partial();
    int f, l;
    bit ok;
    apply_reset();
    clear_mon();
    pulse_start();
    send_word(32'hFC00_0000, 1'b1, 1'b0, f, l);
    wait_done(1'b0);
    checks++;
    if (mem6[0] !== 32'hFC00_0000) begin
      failures++; $display("FAIL illegal_written: got %h required fc000000", mem6[0]);
    end
    repeat (5) tick();
    checks++;
    if (ill6 !== 1'b1) begin
      failures++; $display("FAIL illegal_sticky: got %b required 1", ill6);
    end
    // A new start clears the flag; this load is a 3-byte short word.
    clear_mon();
    pulse_start();
    checks++;
    if (ill6 !== 1'b0) begin
      failures++; $display("FAIL illegal_cleared: got %b required 0", ill6);
    end
    send_byte(8'h8C, 1'b0, 0, 1'b0, ok, f);
    send_byte(8'h22, 1'b0, 0, 1'b0, ok, f);
    send_byte(8'h00, 1'b1, 0, 1'b0, ok, f);
    wait_done(1'b0);
    checks++;
    if (mem6[0] !== 32'h8C22_0000) begin
      failures++; $display("FAIL partial_word: got %h required 8c220000", mem6[0]);
    end
    checks++;
    if ({wc6, ill6} !== {7'd1, 1'b0}) begin
      failures++; $display("FAIL partial_count: got count=%0d ill=%b required 1 0", wc6, ill6);
    end
  endtask

  task automatic test_overflow();
    int f, l;
    bit ok;
    apply_reset();
    clear_mon();
    pulse_start();
    for (int i = 0; i < 4; i++) send_word({8'h20, 8'(i), 8'h00, 8'(i + 1)}, 1'b0, 1'b1, f, l);
    // Fifth word: the small memory is full and no longer accepts bytes.
    send_byte(8'h20, 1'b0, 0, 1'b1, ok, f);
    checks++;
    if (ok !== 1'b0) begin
      failures++; $display("FAIL overflow_ready: extra byte accepted=%b required 0", ok);
    end
    checks++;
    if (done2_cnt !== 1) begin
      failures++; $display("FAIL overflow_done: got %0d pulses required 1", done2_cnt);
    end
    checks++;
    if (wr2 !== 4) begin
      failures++; $display("FAIL overflow_writes: got %0d required 4", wr2);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem2[i] !== {8'h20, 8'(i), 8'h00, 8'(i + 1)}) begin
        failures++; $display("FAIL overflow_word%0d: got %h required %h", i, mem2[i],
                             {8'h20, 8'(i), 8'h00, 8'(i + 1)});
      end
    end
    checks++;
    if ({ovf2, wc2, br2, busy2} !== {1'b1, 3'd4, 1'b0, 1'b0}) begin
      failures++; $display("FAIL overflow_state: got ovf=%b count=%0d ready=%b busy=%b required 1 4 0 0",
                           ovf2, wc2, br2, busy2);
    end
  endtask

  task automatic test_gaps_and_start();
    logic [7:0] bytes [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h41, 8'h00, 8'h08};
    int         gaps  [8] = '{0, 2, 1, 0, 3, 0, 2, 1};
    bit ok;
    int c;
    apply_reset();
    clear_mon();
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i], i == 7, gaps[i], 1'b0, ok, c);
      if (i == 1) pulse_start();
    end
    wait_done(1'b0);
    checks++;
    if ({mem6[0], mem6[1]} !== {32'h2008_0005, 32'hAC41_0008}) begin
      failures++; $display("FAIL gaps_words: got %h %h required 20080005 ac410008", mem6[0], mem6[1]);
    end
    checks++;
    if ({wr6, 25'd0, wc6} !== {32'd2, 25'd0, 7'd2}) begin
      failures++; $display("FAIL gaps_count: got writes=%0d count=%0d required 2 2", wr6, wc6);
    end
    checks++;
    if (dbl_we6 !== 1'b0) begin
      failures++; $display("FAIL gaps_double_we: got %b required 0", dbl_we6);
    end
  endtask

  task automatic test_reset_midload();
    int f, l;
    bit ok;
    apply_reset();
    clear_mon();
    pulse_start();
    send_byte(8'h20, 1'b0, 0, 1'b0, ok, f);
    send_byte(8'h08, 1'b0, 0, 1'b0, ok, f);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({br6, we6, addr6, wdata6, busy6, done6, wc6, ill6, ovf6} !== 51'd0) begin
      failures++;
      $display("FAIL midload_reset: got %h required 0",
               {br6, we6, addr6, wdata6, busy6, done6, wc6, ill6, ovf6});
    end
    @(posedge clk); #1;
    clear_mon();
    pulse_start();
    send_word(32'h1122_3344, 1'b1, 1'b0, f, l);
    wait_done(1'b0);
    checks++;
    if ({mem6[0], last_addr6} !== {32'h1122_3344, 32'd0}) begin
      failures++; $display("FAIL midload_reload: got %h at addr %0d required 11223344 at 0",
                           mem6[0], last_addr6);
    end
    checks++;
    if ({wr6, 25'd0, wc6} !== {32'd1, 25'd0, 7'd1}) begin
      failures++; $display("FAIL midload_count: got writes=%0d count=%0d required 1 1", wr6, wc6);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_two_words();
    test_illegal_then_partial();
    test_overflow();
    test_gaps_and_start();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
